// File: rtl/hazard_ctrl.sv
// Decode-side hazard/sequencing controller: two-entry EX/MEM destination scoreboard,
// stall/bubble/flush generation, memory-busy freeze, HALT drain and stall-cycle counter.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        id_rs_used,
  input  logic [2:0]  id_rs,
  input  logic        id_rt_used,
  input  logic [2:0]  id_rt,
  input  logic        id_wr_en,
  input  logic [2:0]  id_rd,
  input  logic        id_sel_pc_new,
  input  logic        id_halt,
  input  logic        mem_busy,
  output logic        stall,
  output logic        id_ex_bubble,
  output logic        if_id_flush,
  output logic        freeze,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  logic [1:0] state;
  logic       ex_v, mem_v;
  logic [2:0] ex_rd, mem_rd;
  logic       rs_match, rt_match, haz;

  // Only EX and MEM producers matter; a WB write is bypassed inside the register file.
  assign rs_match = (ex_v & (ex_rd == id_rs)) | (mem_v & (mem_rd == id_rs));
  assign rt_match = (ex_v & (ex_rd == id_rt)) | (mem_v & (mem_rd == id_rt));
  assign haz      = id_valid & ((id_rs_used & rs_match) | (id_rt_used & rt_match));

  assign freeze       = mem_busy & ~rst;
  assign stall        = ~rst & (freeze | haz | (state != S_RUN) | (id_valid & id_halt));
  assign id_ex_bubble = ~rst & ~freeze & (stall | ~id_valid);
  assign if_id_flush  = ~rst & id_valid & id_sel_pc_new & ~stall & ~freeze;
  // Gated so every single-bit output reads 0 while reset is held.
  assign halted       = ~rst & (state == S_HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_RUN;
      ex_v   <= 1'b0;
      ex_rd  <= 3'd0;
      mem_v  <= 1'b0;
      mem_rd <= 3'd0;
    end else begin
      if (!freeze) begin
        mem_v  <= ex_v;
        mem_rd <= ex_rd;
        ex_v   <= id_valid & id_wr_en & ~id_ex_bubble & ~id_halt;
        ex_rd  <= id_rd;
      end
      case (state)
        S_RUN:    if (id_valid & id_halt & ~haz & ~mem_busy) state <= S_DRAIN;
        S_DRAIN:  if (~ex_v & ~mem_v & ~mem_busy) state <= S_HALTED;
        S_HALTED: state <= S_HALTED;
        default:  state <= S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= 16'd0;
    else if ((state != S_HALTED) && (stall | freeze) && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-scenario tasks with hand-computed expectations.
module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_rs_used, id_rt_used, id_wr_en, id_sel_pc_new, id_halt, mem_busy;
  logic [2:0]  id_rs, id_rt, id_rd;
  logic        stall, id_ex_bubble, if_id_flush, freeze, halted;
  logic [15:0] stall_cnt;
  logic [4:0]  obs;
  int          total = 0;
  int          bad = 0;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs_used(id_rs_used), .id_rs(id_rs), .id_rt_used(id_rt_used), .id_rt(id_rt),
    .id_wr_en(id_wr_en), .id_rd(id_rd), .id_sel_pc_new(id_sel_pc_new),
    .id_halt(id_halt), .mem_busy(mem_busy),
    .stall(stall), .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
    .freeze(freeze), .halted(halted), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;
  // {stall, id_ex_bubble, if_id_flush, freeze, halted}
  assign obs = {stall, id_ex_bubble, if_id_flush, freeze, halted};

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle;
    id_valid = 0; id_rs_used = 0; id_rs = 0; id_rt_used = 0; id_rt = 0;
    id_wr_en = 0; id_rd = 0; id_sel_pc_new = 0; id_halt = 0; mem_busy = 0;
  endtask

  task automatic instr(input logic v, input logic ru, input logic [2:0] rs,
                       input logic tu, input logic [2:0] rt,
                       input logic we, input logic [2:0] rd);
    idle;
    id_valid = v; id_rs_used = ru; id_rs = rs; id_rt_used = tu; id_rt = rt;
    id_wr_en = we; id_rd = rd;
  endtask

  task automatic do_reset;
    idle; rst = 1; tick; rst = 0;
  endtask

  task automatic test_reset;
    rst = 1; id_valid = 1; id_halt = 1; id_sel_pc_new = 1; mem_busy = 1; #1;
    total++; if (obs !== 5'b00000) begin bad++; $display("FAIL reset_outs got %b want 00000", obs); end
    tick; rst = 0; idle; #1;
    total++; if (obs !== 5'b01000) begin bad++; $display("FAIL reset_idle got %b want 01000", obs); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got %0d want 0", stall_cnt); end
  endtask

  task automatic test_raw;
    do_reset;
    instr(1, 0, 0, 0, 0, 1, 1); #1;
    total++; if (obs !== 5'b00000) begin bad++; $display("FAIL raw_c0 got %b want 00000", obs); end
    tick; instr(1, 1, 1, 1, 3, 1, 2); #1;
    total++; if (obs !== 5'b11000) begin bad++; $display("FAIL raw_c1 got %b want 11000", obs); end
    tick; #1;
    total++; if (obs !== 5'b11000) begin bad++; $display("FAIL raw_c2 got %b want 11000", obs); end
    tick; #1;
    total++; if (obs !== 5'b00000) begin bad++; $display("FAIL raw_c3 got %b want 00000", obs); end
    total++; if (stall_cnt !== 16'd2) begin bad++; $display("FAIL raw_cnt got %0d want 2", stall_cnt); end
    tick; idle;
  endtask

  task automatic test_branch;
    do_reset;
    instr(1, 0, 0, 0, 0, 1, 4); tick;
    instr(1, 0, 0, 0, 0, 1, 6); #1;
    total++; if (obs !== 5'b00000) begin bad++; $display("FAIL br_gap got %b want 00000", obs); end
    tick; instr(1, 1, 4, 0, 0, 0, 0); id_sel_pc_new = 1; #1;
    total++; if (obs !== 5'b11000) begin bad++; $display("FAIL br_stall got %b want 11000", obs); end
    tick; #1;
    total++; if (obs !== 5'b00100) begin bad++; $display("FAIL br_flush got %b want 00100", obs); end
    total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL br_cnt got %0d want 1", stall_cnt); end
    tick; idle;
  endtask

  task automatic test_freeze;
    do_reset;
    instr(1, 0, 0, 0, 0, 1, 5); tick;
    instr(1, 1, 5, 0, 0, 1, 2); mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (obs !== 5'b10010) begin bad++; $display("FAIL frz_c%0d got %b want 10010", i, obs); end
      total++; if ({dut.ex_v, dut.ex_rd} !== 4'b1101) begin bad++; $display("FAIL frz_ex%0d got %b want 1101", i, {dut.ex_v, dut.ex_rd}); end
      tick;
    end
    mem_busy = 0; #1;
    total++; if (obs !== 5'b11000) begin bad++; $display("FAIL frz_s1 got %b want 11000", obs); end
    tick; #1;
    total++; if (obs !== 5'b11000) begin bad++; $display("FAIL frz_s2 got %b want 11000", obs); end
    tick; #1;
    total++; if (obs !== 5'b00000) begin bad++; $display("FAIL frz_go got %b want 00000", obs); end
    total++; if (stall_cnt !== 16'd5) begin bad++; $display("FAIL frz_cnt got %0d want 5", stall_cnt); end
    tick; idle;
  endtask

  task automatic test_flush_busy;
    do_reset;
    instr(1, 0, 0, 0, 0, 0, 0); id_sel_pc_new = 1; mem_busy = 1; #1;
    total++; if (obs !== 5'b10010) begin bad++; $display("FAIL fb_busy got %b want 10010", obs); end
    tick; mem_busy = 0; #1;
    total++; if (obs !== 5'b00100) begin bad++; $display("FAIL fb_flush got %b want 00100", obs); end
    tick; idle;
  endtask

  task automatic test_halt;
    do_reset;
    instr(1, 0, 0, 0, 0, 1, 1); tick;
    instr(1, 0, 0, 0, 0, 1, 2); tick;
    instr(1, 0, 0, 0, 0, 0, 0); id_halt = 1; #1;
    total++; if (obs !== 5'b11000) begin bad++; $display("FAIL halt_c2 got %b want 11000", obs); end
    tick; #1;
    total++; if (obs !== 5'b11000) begin bad++; $display("FAIL halt_c3 got %b want 11000", obs); end
    tick; #1;
    total++; if (obs !== 5'b11000) begin bad++; $display("FAIL halt_c4 got %b want 11000", obs); end
    tick; #1;
    total++; if (obs !== 5'b11001) begin bad++; $display("FAIL halt_c5 got %b want 11001", obs); end
    tick; tick; #1;
    total++; if (obs !== 5'b11001) begin bad++; $display("FAIL halt_hold got %b want 11001", obs); end
    total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL halt_cnt got %0d want 3", stall_cnt); end
    rst = 1; #1;
    total++; if (obs !== 5'b00000) begin bad++; $display("FAIL halt_rst got %b want 00000", obs); end
    tick; rst = 0; idle; #1;
    total++; if (obs !== 5'b01000) begin bad++; $display("FAIL halt_run got %b want 01000", obs); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL halt_cnt0 got %0d want 0", stall_cnt); end
  endtask

  task automatic test_saturate;
    do_reset;
    mem_busy = 1;
    repeat (70000) @(posedge clk);
    #1;
    total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_cnt got %h want ffff", stall_cnt); end
    rst = 1; tick; rst = 0; idle; #1;
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL sat_rst got %0d want 0", stall_cnt); end
  endtask

  task automatic test_invalid_src;
    do_reset;
    instr(1, 0, 0, 0, 0, 1, 3); tick;
    instr(0, 1, 3, 0, 0, 0, 0); #1;
    total++; if (obs !== 5'b01000) begin bad++; $display("FAIL inv_src got %b want 01000", obs); end
    tick; idle;
  endtask

  task automatic test_r0_rst_mid_stall;
    do_reset;
    instr(1, 0, 0, 0, 0, 1, 0); tick;
    instr(1, 1, 0, 1, 0, 1, 0); #1;
    total++; if (obs !== 5'b11000) begin bad++; $display("FAIL r0_haz got %b want 11000", obs); end
    rst = 1; #1;
    total++; if (obs !== 5'b00000) begin bad++; $display("FAIL mid_rst got %b want 00000", obs); end
    tick; rst = 0; #1;
    total++; if (obs !== 5'b00000) begin bad++; $display("FAIL post_rst got %b want 00000", obs); end
    total++; if ({dut.ex_v, dut.mem_v} !== 2'b00) begin bad++; $display("FAIL post_rst_sb got %b want 00", {dut.ex_v, dut.mem_v}); end
    tick; idle;
  endtask

  initial begin
    idle; rst = 1;
    tick;
    test_reset;
    test_raw;
    test_branch;
    test_freeze;
    test_flush_busy;
    test_halt;
    test_invalid_src;
    test_r0_rst_mid_stall;
    test_saturate;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
